// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_pkg
//  Brief    : Shared constants and divider state encoding for the PWM
//             generator / capture pair.
//  Revision : 1.0  initial release
// ============================================================================
package pwm_pkg;

  // Duty code width shared by the PWM generator and the capture block.
  localparam int PWM_WIDTH = 8;

  // Duty divider sequencing.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_duty_div.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_duty_div
//  Brief    : WIDTH-cycle restoring divider producing
//             floor(high * 2^WIDTH / period), MSB first. high < period.
//  Revision : 1.0  initial release
// ============================================================================
module pwm_duty_div
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] high,
  input  logic [CNT_W-1:0] period,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int             SW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [SW-1:0]  LAST = SW'(WIDTH - 1);

  div_state_t       state;
  logic [CNT_W:0]   rem;
  logic [CNT_W-1:0] divisor;
  logic [WIDTH-2:0] q_bits;
  logic [SW-1:0]    step;

  logic [CNT_W:0]   shifted;
  logic [CNT_W:0]   diff;
  logic             q_bit;

  // One restoring step: rem never reaches 2^CNT_W, so the shift cannot overflow.
  always_comb begin
    shifted  = rem << 1;
    diff     = shifted - {1'b0, divisor};
    q_bit    = (shifted >= {1'b0, divisor});
    quotient = {q_bits, q_bit};
    busy     = (state == DIV);
    done     = (state == DIV) && (step == LAST);
  end

  // Divider sequencing; DONE behaves as idle so a back-to-back start is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rem     <= '0;
      divisor <= '0;
      q_bits  <= '0;
      step    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            rem     <= {1'b0, high};
            divisor <= period;
            q_bits  <= '0;
            step    <= '0;
            state   <= DIV;
          end else begin
            state   <= IDLE;
          end
        end
        DIV: begin
          rem    <= q_bit ? diff : shifted;
          q_bits <= quotient[WIDTH-2:0];
          step   <= step + 1'b1;
          if (done) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : pwm_duty_div
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_capture
//  Brief    : PWM receiver. Measures high time and period of an external PWM
//             line and converts them to a WIDTH-bit duty code.
//  Revision : 1.0  initial release
// ============================================================================
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pwm_i,
  output logic [WIDTH-1:0] duty_o,
  output logic [CNT_W-1:0] high_o,
  output logic [CNT_W-1:0] period_o,
  output logic             valid_o,
  output logic             stuck_o,
  output logic             overrun_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1, s2, s3;
  logic             rise;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic             armed;

  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quot;

  assign rise      = s2 & ~s3;
  assign div_start = rise & armed & ~div_busy;

  // Two-flop synchronizer plus one delay stage for rising-edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // The rise cycle itself counts as the first cycle of the new period, and it
  // is always high, so both counters restart at 1 to give exact H and H+L.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= CNT_W'(1);
      hi_cnt  <= CNT_W'(1);
    end else begin
      if (per_cnt != CNT_MAX)       per_cnt <= per_cnt + 1'b1;
      if (s2 && hi_cnt != CNT_MAX)  hi_cnt  <= hi_cnt + 1'b1;
    end
  end

  // Arming, measurement latch, overrun, stuck detection and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      armed     <= 1'b0;
      duty_o    <= '0;
      high_o    <= '0;
      period_o  <= '0;
      valid_o   <= 1'b0;
      stuck_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
      if (rise) begin
        stuck_o <= 1'b0;
        if (!armed) begin
          armed <= 1'b1;
        end else if (div_busy) begin
          overrun_o <= 1'b1;
        end else begin
          high_o   <= hi_cnt;
          period_o <= per_cnt;
        end
      end else if (armed && per_cnt == CNT_MAX) begin
        // Line frozen: report its level as 0% or 100% and wait for a re-arm.
        armed   <= 1'b0;
        stuck_o <= 1'b1;
        duty_o  <= {WIDTH{s2}};
        valid_o <= 1'b1;
      end
      if (div_done) begin
        duty_o  <= div_quot;
        valid_o <= 1'b1;
      end
    end
  end

  pwm_duty_div #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_div (
    .clk      (clk_i),
    .rst      (rst_i),
    .start    (div_start),
    .high     (hi_cnt),
    .period   (per_cnt),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

endmodule : pwm_capture
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_capture
//  Brief    : Scoreboard bench for pwm_capture (WIDTH=8, CNT_W=12).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwm_capture;

  localparam int W  = 8;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pwm = 1'b0;
  logic [W-1:0]  duty;
  logic [CW-1:0] high;
  logic [CW-1:0] period;
  logic          valid;
  logic          stuck;
  logic          overrun;

  pwm_capture #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .pwm_i     (pwm),
    .duty_o    (duty),
    .high_o    (high),
    .period_o  (period),
    .valid_o   (valid),
    .stuck_o   (stuck),
    .overrun_o (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  typedef struct {
    int cyc;
    int duty;
    int hi;
    int per;
    int stk;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  bit armed     = 1'b0;
  int cur_h     = 0;
  int cur_l     = 0;
  int last_d    = 0;
  int last_acc  = -1000;
  int last_hi   = 0;
  int last_per  = 0;
  int exp_ovr   = 0;
  int ovr_seen  = 0;

  task automatic push(input int c, input int d, input int h, input int p, input int s);
    exp_t e;
    e.cyc = c; e.duty = d; e.hi = h; e.per = p; e.stk = s;
    sb.push_back(e);
  endtask

  // Called right after the bench raises pwm. The synchronizer places the
  // detected rise 2 cycles later; a result appears 9 cycles after that.
  task automatic on_rise(input int h, input int l);
    int d;
    d = cyc;
    if (armed) begin
      if (d - last_acc >= 9) begin
        push(d + 11, (cur_h * 256) / (cur_h + cur_l), cur_h, cur_h + cur_l, 0);
        last_acc = d;
        last_hi  = cur_h;
        last_per = cur_h + cur_l;
      end else begin
        exp_ovr++;
      end
    end else begin
      armed = 1'b1;
    end
    cur_h  = h;
    cur_l  = l;
    last_d = d;
  endtask

  task automatic run(input int h, input int l, input int n);
    repeat (n) begin
      @(posedge clk); #1 pwm = 1'b1;
      on_rise(h, l);
      repeat (h - 1) @(posedge clk);
      @(posedge clk); #1 pwm = 1'b0;
      repeat (l - 1) @(posedge clk);
    end
  endtask

  task automatic stuck_high();
    @(posedge clk); #1 pwm = 1'b1;
    on_rise(0, 0);
    push(last_d + 4098, 255, last_hi, last_per, 1);
    armed = 1'b0;
    repeat (4200) @(posedge clk);
  endtask

  task automatic stuck_low();
    push(last_d + 4098, 0, last_hi, last_per, 1);
    armed = 1'b0;
    repeat (4200) @(posedge clk);
  endtask

  // Output monitor: every valid pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (overrun) ovr_seen++;
      if (valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("valid_cycle", cyc, e.cyc);
          check("duty", duty, e.duty);
          check("high", high, e.hi);
          check("period", period, e.per);
          check("stuck", stuck, e.stk);
        end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
        check("missed_valid", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    // Reset held with the line toggling
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 pwm = ~pwm;
    end
    @(negedge clk);
    check("rst_duty", duty, 0);
    check("rst_high", high, 0);
    check("rst_period", period, 0);
    check("rst_valid", valid, 0);
    check("rst_stuck", stuck, 0);
    check("rst_overrun", overrun, 0);
    @(posedge clk); #1 pwm = 1'b0; rst = 1'b0;
    repeat (4) @(posedge clk);

    // Steady 25% waveform
    run(64, 192, 4);

    // Reset in the middle of a divide: result dropped, re-arm required
    @(posedge clk); #1 pwm = 1'b1;
    on_rise(64, 192);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1; pwm = 1'b0;
    sb.delete();
    armed = 1'b0;
    last_acc = -1000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    check("post_rst_valid", valid, 0);
    run(64, 192, 3);

    // Short periods (overruns between accepted ones) and near-100% duty
    run(1, 2, 12);
    run(255, 1, 3);

    // Stuck high, then release and re-arm
    stuck_high();
    check("stuck_high_flag", stuck, 1);
    @(posedge clk); #1 pwm = 1'b0;
    repeat (127) @(posedge clk);
    run(128, 128, 1);
    check("stuck_cleared", stuck, 0);
    run(128, 128, 2);

    // Stuck low
    stuck_low();
    check("stuck_low_flag", stuck, 1);
    check("stuck_low_duty", duty, 0);

    // Overrun-heavy waveform
    run(2, 2, 14);
    repeat (30) @(posedge clk);

    check("sb_drained", sb.size(), 0);
    check("overrun_count", ovr_seen, exp_ovr);
    check("overrun_seen", (exp_ovr > 0) ? 1 : 0, 1);
    check("final_stuck", stuck, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pwm_capture
`default_nettype wire
